// File: rtl/debounce_multi.sv
// rtl/debounce_multi.sv - N-channel switch debouncer with synchroniser, stability counter and edge strobes
module debounce_multi #(
    parameter int N           = 4,
    parameter int DELAY       = 10000,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] en,
    input  logic [N-1:0] din,
    output logic [N-1:0] db_out,
    output logic [N-1:0] rise,
    output logic [N-1:0] fall,
    output logic         any_edge
);

    localparam int CNT_W = $clog2(DELAY + 1);
    localparam logic [CNT_W-1:0] DELAY_C = CNT_W'(DELAY);

    logic [SYNC_STAGES-1:0] sync_q [N];
    logic [N-1:0]           cand;
    logic [CNT_W-1:0]       cnt    [N];
    logic [N-1:0]           s;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            s[i] = sync_q[i][SYNC_STAGES-1];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (!reset) begin
                // Preload everything from the pin so reset release emits no strobe
                sync_q[i] <= {SYNC_STAGES{din[i]}};
                cand[i]   <= din[i];
                cnt[i]    <= '0;
                db_out[i] <= din[i];
                rise[i]   <= 1'b0;
                fall[i]   <= 1'b0;
            end else begin
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], din[i]};
                rise[i]   <= 1'b0;
                fall[i]   <= 1'b0;
                if (!en[i]) begin
                    cand[i] <= s[i];
                    cnt[i]  <= '0;
                end else if (s[i] != cand[i]) begin
                    cand[i] <= s[i];
                    cnt[i]  <= '0;
                end else if (cnt[i] != DELAY_C) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end else if (cand[i] != db_out[i]) begin
                    // Counter saturates at DELAY; the level commits once and strobes once
                    db_out[i] <= cand[i];
                    rise[i]   <= cand[i];
                    fall[i]   <= ~cand[i];
                end
            end
        end
    end

    assign any_edge = |(rise | fall);

endmodule

// File: tb/tb_debounce_multi.sv
// tb/tb_debounce_multi.sv - directed self-checking bench for debounce_multi
module tb_debounce_multi;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] en;
    logic [3:0] din;
    logic [3:0] db_out;
    logic [3:0] rise;
    logic [3:0] fall;
    logic       any_edge;

    int n_assert = 0;
    int n_fail   = 0;

    debounce_multi #(.N(4), .DELAY(4), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .din      (din),
        .db_out   (db_out),
        .rise     (rise),
        .fall     (fall),
        .any_edge (any_edge)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] e_db, input logic [3:0] e_rise,
                         input logic [3:0] e_fall);
        logic e_any;
        e_any = |(e_rise | e_fall);
        n_assert++;
        assert (db_out === e_db) else begin
            n_fail++;
            $error("FAIL %s db_out: observed %b expected %b", tag, db_out, e_db);
        end
        n_assert++;
        assert (rise === e_rise) else begin
            n_fail++;
            $error("FAIL %s rise: observed %b expected %b", tag, rise, e_rise);
        end
        n_assert++;
        assert (fall === e_fall) else begin
            n_fail++;
            $error("FAIL %s fall: observed %b expected %b", tag, fall, e_fall);
        end
        n_assert++;
        assert (any_edge === e_any) else begin
            n_fail++;
            $error("FAIL %s any_edge: observed %b expected %b", tag, any_edge, e_any);
        end
    endtask

    initial begin
        reset = 1'b0;
        en    = 4'b1111;
        din   = 4'b0101;
        tick(); tick(); tick();
        check("reset", 4'b0101, 4'b0000, 4'b0000);
        reset = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            check("release", 4'b0101, 4'b0000, 4'b0000);
        end

        // Drop channels 0 and 2: fall strobes on both at edge 8
        din = 4'b0000;
        for (int k = 1; k <= 10; k++) begin
            tick();
            check("fall02", (k >= 8) ? 4'b0000 : 4'b0101, 4'b0000, (k == 8) ? 4'b0101 : 4'b0000);
        end

        // Clean step on channel 0
        din[0] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            check("rise0", (k >= 8) ? 4'b0001 : 4'b0000, (k == 8) ? 4'b0001 : 4'b0000, 4'b0000);
        end

        // 3-clock glitch on channel 1 is rejected
        for (int k = 1; k <= 14; k++) begin
            din[1] = (k <= 3);
            tick();
            check("glitch1", 4'b0001, 4'b0000, 4'b0000);
        end

        // 6-clock pulse on channel 1 qualifies both edges
        for (int k = 1; k <= 16; k++) begin
            din[1] = (k <= 6);
            tick();
            check("pulse1", (k >= 8 && k < 14) ? 4'b0011 : 4'b0001,
                  (k == 8) ? 4'b0010 : 4'b0000, (k == 14) ? 4'b0010 : 4'b0000);
        end

        // Frozen channel 2 ignores toggling
        en[2] = 1'b0;
        for (int k = 1; k <= 23; k++) begin
            din[2] = (k >= 20) ? 1'b1 : ((k % 2) == 0);
            tick();
            check("frozen2", 4'b0001, 4'b0000, 4'b0000);
        end
        en[2] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check("reen2", (k >= 5) ? 4'b0101 : 4'b0001, (k == 5) ? 4'b0100 : 4'b0000, 4'b0000);
        end

        // Bring channel 3 high
        din[3] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            check("rise3", (k >= 8) ? 4'b1101 : 4'b0101, (k == 8) ? 4'b1000 : 4'b0000, 4'b0000);
        end

        // Channel 3 falls, reset lands at edge 5 mid-qualification
        din[3] = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check("pre_rst3", 4'b1101, 4'b0000, 4'b0000);
        end
        reset = 1'b0;
        tick();
        check("rst3", 4'b0101, 4'b0000, 4'b0000);
        reset = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            check("post_rst3", 4'b0101, 4'b0000, 4'b0000);
        end

        // All channels toggle together
        din = 4'b1010;
        for (int k = 1; k <= 10; k++) begin
            tick();
            check("all", (k >= 8) ? 4'b1010 : 4'b0101,
                  (k == 8) ? 4'b1010 : 4'b0000, (k == 8) ? 4'b0101 : 4'b0000);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
